// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   seg_t    - segments g..a, active low (bit 6 = g, bit 0 = a)
//   HEX2SEG  - full hex glyph table, active low; the dp bit (bit 7) is
//              not stored here and is merged in by the scan driver
//   SEG_OFF  - cathode pattern for a dark digit
//   AN_OFF   - anode pattern with no digit selected
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Index = nibble value. Glyphs: 0-9, A, b, C, d, E, F.
    localparam seg_t HEX2SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment glyph decoder.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its input.
//
// Ports:
//   nibble - 4-bit hex/BCD code
//   seg    - segments g..a, active low
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX2SEG[nibble];

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Latency: outputs registered, 1 cycle after the digit index selects a slot.
// Backpressure: none; free-running display sink, inputs sampled once per frame.
//
// Ports:
//   clock, reset - system clock; asynchronous active-high reset
//   digits[31:0] - eight 4-bit codes, digit i at [4i+3:4i], digit 0 rightmost
//   dp[7:0]      - decimal point request per digit, active high
//   en[7:0]      - digit enable; 0 blanks the digit entirely
//   an[7:0]      - anode selects, active low, at most one low
//   dec_cat[7:0] - cathodes, active low: {dp, g, f, e, d, c, b, a}
//
// Build option: define SEG7_LZB_EN to enable leading-zero blanking
// (digits 7..1 that are zero with all higher digits also zero show no
// segments; anode and dp still driven; digit 0 never blanked).
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int CLOCK_FREQ    = 100_000_000,
    parameter int DIGIT_RATE_HZ = 8000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  en,
    output logic [7:0]  an,
    output logic [7:0]  dec_cat
);

    localparam int TICK_RAW = CLOCK_FREQ / DIGIT_RATE_HZ;
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    // Frame shadow: the values every digit of the current frame is drawn from.
    logic [31:0] sh_digits;
    logic [7:0]  sh_dp;
    logic [7:0]  sh_en;

    logic        frame_load;
    logic [31:0] cur_digits;
    logic [7:0]  cur_dp;
    logic [7:0]  cur_en;
    logic [3:0]  cur_nib;
    seg_t        cur_seg;
    seg_t        lit_seg;

    // First cycle of a frame. The shadow loads on this edge, and the live
    // inputs are used directly so digit 0 never shows the previous frame.
    assign frame_load = (idx == 3'd0) && (cnt == '0);

    assign cur_digits = frame_load ? digits : sh_digits;
    assign cur_dp     = frame_load ? dp     : sh_dp;
    assign cur_en     = frame_load ? en     : sh_en;
    assign cur_nib    = cur_digits[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

`ifdef SEG7_LZB_EN
    logic [7:0] lzb_live;
    logic [7:0] sh_lzb;
    logic [7:0] cur_lzb;
    logic       zero_run;

    // Walk down from digit 7; a digit is blankable while every digit at or
    // above it is zero. Bit 0 stays clear so a value of zero still shows "0".
    always_comb begin
        lzb_live = '0;
        zero_run = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_run    = zero_run && (digits[4*i +: 4] == 4'h0);
            lzb_live[i] = zero_run;
        end
    end

    assign cur_lzb = frame_load ? lzb_live : sh_lzb;
    assign lit_seg = cur_lzb[idx] ? 7'h7F : cur_seg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_lzb <= '0;
        end else if (frame_load) begin
            sh_lzb <= lzb_live;
        end
    end
`else
    assign lit_seg = cur_seg;
`endif

    // Divider and digit index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Frame shadow registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
        end else if (frame_load) begin
            sh_digits <= digits;
            sh_dp     <= dp;
            sh_en     <= en;
        end
    end

    // Output register; a disabled slot keeps every anode and cathode dark.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an      <= AN_OFF;
            dec_cat <= SEG_OFF;
        end else if (cur_en[idx]) begin
            an      <= ~(8'h01 << idx);
            dec_cat <= {~cur_dp[idx], lit_seg};
        end else begin
            an      <= AN_OFF;
            dec_cat <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Self-checking bench for seg7_scan_drv with TICK_DIV = 10 (100 Hz / 10 Hz).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seg7_scan_drv;

    logic        clock;
    logic        reset;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [7:0]  an;
    logic [7:0]  dec_cat;

    seg7_scan_drv #(
        .CLOCK_FREQ    (100),
        .DIGIT_RATE_HZ (10)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .digits  (digits),
        .dp      (dp),
        .en      (en),
        .an      (an),
        .dec_cat (dec_cat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] an_v;
        logic [7:0] dec_v;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int kcnt     = 0;   // index of the next rising edge since reset release

    logic [31:0] m_d;
    logic [7:0]  m_p;
    logic [7:0]  m_e;

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g[6:0];
    endfunction

    // Reference model: expected outputs after rising edge number kcnt.
    task automatic model_step(output logic [7:0] ea, output logic [7:0] ed);
        int         i;
        logic [3:0] nib;
        logic       blank;
        if (kcnt % 80 == 0) begin
            m_d = digits;
            m_p = dp;
            m_e = en;
        end
        i     = (kcnt / 10) % 8;
        nib   = m_d[i*4 +: 4];
        blank = 1'b0;
`ifdef SEG7_LZB_EN
        if (i != 0) begin
            blank = 1'b1;
            for (int j = i; j < 8; j++)
                if (m_d[j*4 +: 4] != 4'h0) blank = 1'b0;
        end
`endif
        ea = 8'hFF;
        ed = 8'hFF;
        if (m_e[i]) begin
            ea[i] = 1'b0;
            ed    = {~m_p[i], blank ? 7'h7F : seg_ref(nib)};
        end
    endtask

    task automatic tick();
        @(posedge clock);
        kcnt++;
        @(negedge clock);
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [7:0] ea, ed;
        reset  = 1'b1;
        digits = 32'h76543210;
        en     = 8'hFF;
        dp     = 8'h00;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (an !== 8'hFF) begin
                failures++;
                $display("FAIL reset_an got=%h exp=FF", an);
            end
            checks++;
            if (dec_cat !== 8'hFF) begin
                failures++;
                $display("FAIL reset_dec got=%h exp=FF", dec_cat);
            end
        end
        reset = 1'b0;
        kcnt  = 0;
        model_step(ea, ed);
        sb.push_back('{an_v: ea, dec_v: ed});
        tick();
        e = sb.pop_front();
        checks++;
        if (an !== 8'hFE || an !== e.an_v) begin
            failures++;
            $display("FAIL release_an got=%h exp=FE", an);
        end
        checks++;
        if (dec_cat !== 8'hC0 || dec_cat !== e.dec_v) begin
            failures++;
            $display("FAIL release_dec got=%h exp=C0", dec_cat);
        end
    endtask

    task automatic test_scan_order();
        exp_t       e;
        logic [7:0] ea, ed;
        int         ki;
        for (int c = 0; c < 90; c++) begin
            ki = kcnt;
            model_step(ea, ed);
            sb.push_back('{an_v: ea, dec_v: ed});
            tick();
            e = sb.pop_front();
            checks++;
            if (an !== e.an_v) begin
                failures++;
                $display("FAIL scan_an k=%0d got=%h exp=%h", ki, an, e.an_v);
            end
            checks++;
            if (dec_cat !== e.dec_v) begin
                failures++;
                $display("FAIL scan_dec k=%0d got=%h exp=%h", ki, dec_cat, e.dec_v);
            end
        end
    endtask

    task automatic test_dp_en();
        exp_t       e;
        logic [7:0] ea, ed;
        int         ki, fstart;
        dp     = 8'h04;
        en     = 8'hF7;
        fstart = (kcnt / 80 + 1) * 80;
        while (kcnt < fstart + 80) begin
            ki = kcnt;
            model_step(ea, ed);
            sb.push_back('{an_v: ea, dec_v: ed});
            tick();
            e = sb.pop_front();
            checks++;
            if (an !== e.an_v || dec_cat !== e.dec_v) begin
                failures++;
                $display("FAIL dpen k=%0d got=%h/%h exp=%h/%h", ki, an, dec_cat, e.an_v, e.dec_v);
            end
            if (ki >= fstart && (ki % 80) / 10 == 2) begin
                checks++;
                if (dec_cat[7] !== 1'b0) begin
                    failures++;
                    $display("FAIL dp_slot2 k=%0d got=%b exp=0", ki, dec_cat[7]);
                end
            end
            if (ki >= fstart && (ki % 80) / 10 == 3) begin
                checks++;
                if (an !== 8'hFF || dec_cat !== 8'hFF) begin
                    failures++;
                    $display("FAIL en_slot3 k=%0d got=%h/%h exp=FF/FF", ki, an, dec_cat);
                end
            end
        end
    endtask

    task automatic test_frame_coherency();
        exp_t       e;
        logic [7:0] ea, ed;
        int         ki, fnext;
        bit         changed;
        changed = 1'b0;
        fnext   = (kcnt / 80 + 1) * 80;
        while (kcnt <= fnext) begin
            if (!changed && (kcnt % 80) / 10 == 3) begin
                digits  = 32'h88888888;
                changed = 1'b1;
            end
            ki = kcnt;
            model_step(ea, ed);
            sb.push_back('{an_v: ea, dec_v: ed});
            tick();
            e = sb.pop_front();
            checks++;
            if (an !== e.an_v || dec_cat !== e.dec_v) begin
                failures++;
                $display("FAIL coh k=%0d got=%h/%h exp=%h/%h", ki, an, dec_cat, e.an_v, e.dec_v);
            end
            if (changed && ki < fnext && (ki % 80) / 10 == 4) begin
                checks++;
                if (dec_cat !== 8'h99) begin
                    failures++;
                    $display("FAIL coh_old_digit4 k=%0d got=%h exp=99", ki, dec_cat);
                end
            end
            if (ki == fnext) begin
                checks++;
                if (an !== 8'hFE || dec_cat !== 8'h80) begin
                    failures++;
                    $display("FAIL coh_new_frame got=%h/%h exp=FE/80", an, dec_cat);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t       e;
        logic [7:0] ea, ed;
        int         ki, guard;
        guard = 0;
        while (((kcnt - 1) % 80) / 10 != 5 && guard < 100) begin
            model_step(ea, ed);
            sb.push_back('{an_v: ea, dec_v: ed});
            tick();
            e = sb.pop_front();
            guard++;
            checks++;
            if (an !== e.an_v || dec_cat !== e.dec_v) begin
                failures++;
                $display("FAIL pre_rst k=%0d got=%h/%h exp=%h/%h", kcnt - 1, an, dec_cat, e.an_v, e.dec_v);
            end
        end
        checks++;
        if (an !== 8'hDF) begin
            failures++;
            $display("FAIL pre_rst_slot5 got=%h exp=DF", an);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (an !== 8'hFF || dec_cat !== 8'hFF) begin
            failures++;
            $display("FAIL async_rst got=%h/%h exp=FF/FF", an, dec_cat);
        end
        @(negedge clock);
        reset = 1'b0;
        kcnt  = 0;
        for (int c = 0; c < 20; c++) begin
            ki = kcnt;
            model_step(ea, ed);
            sb.push_back('{an_v: ea, dec_v: ed});
            tick();
            e = sb.pop_front();
            checks++;
            if (an !== e.an_v || dec_cat !== e.dec_v) begin
                failures++;
                $display("FAIL post_rst k=%0d got=%h/%h exp=%h/%h", ki, an, dec_cat, e.an_v, e.dec_v);
            end
            if (ki == 0) begin
                checks++;
                if (an !== 8'hFE) begin
                    failures++;
                    $display("FAIL post_rst_first_an got=%h exp=FE", an);
                end
            end
        end
    endtask

`ifdef SEG7_LZB_EN
    task automatic test_lzb();
        exp_t       e;
        logic [7:0] ea, ed;
        logic [7:0] want [8];
        int         ki, slot;
        want = '{8'h92, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        reset  = 1'b1;
        digits = 32'h00000105;
        dp     = 8'h00;
        en     = 8'hFF;
        tick();
        reset = 1'b0;
        kcnt  = 0;
        for (int c = 0; c < 80; c++) begin
            ki = kcnt;
            model_step(ea, ed);
            sb.push_back('{an_v: ea, dec_v: ed});
            tick();
            e = sb.pop_front();
            slot = ki / 10;
            checks++;
            if (an !== e.an_v || dec_cat !== e.dec_v) begin
                failures++;
                $display("FAIL lzb k=%0d got=%h/%h exp=%h/%h", ki, an, dec_cat, e.an_v, e.dec_v);
            end
            if (ki % 10 == 0) begin
                checks++;
                if (dec_cat !== want[slot] || an[slot] !== 1'b0) begin
                    failures++;
                    $display("FAIL lzb_slot%0d got=%h/%h exp_dec=%h", slot, an, dec_cat, want[slot]);
                end
            end
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        digits = 32'h0;
        dp     = 8'h0;
        en     = 8'h0;
        @(negedge clock);
        test_reset();
        test_scan_order();
        test_dp_en();
        test_frame_coherency();
        test_async_reset();
`ifdef SEG7_LZB_EN
        test_lzb();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
